// File: rtl/systolic_array_mxn.sv
// rtl/systolic_array_mxn.sv - output-stationary N x M systolic GEMM engine with internal operand skew
// Define SYSTOLIC_SAT_EN to clamp results to the signed CW range on capture (default: truncate).

module systolic_array_mxn #(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int DW   = 8,
    parameter int ACCW = 20,
    parameter int CW   = 16,
    parameter int KMAX = 255,
    parameter int KW   = $clog2(KMAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KW-1:0]     k_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   a_col_flat,
    input  logic [M*DW-1:0]   b_row_flat,
    output logic              busy,
    output logic              done,
    output logic              c_valid,
    output logic [N*M*CW-1:0] C_flat
);
    localparam int DCW = $clog2(N + M + 1);
    localparam int PW  = 2 * DW;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (CW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic [1:0]          state_q, state_d;
    logic [KW-1:0]       k_q, k_d, beat_q, beat_d;
    logic [DCW-1:0]      drain_q, drain_d;
    logic                done_q, done_d, cvalid_q, cvalid_d;
    logic [N*M*CW-1:0]   c_q, c_d;
    logic                fire, clear;

    // Operand buses carry {valid, data}; bubbles travel as valid=0.
    logic [N-1:0][M-1:0][DW:0]   a_in, b_in;
    logic [N-1:0][M-1:0][ACCW-1:0] acc_w;

    assign in_ready = (state_q == S_STREAM);
    assign fire     = in_ready && in_valid;
    assign clear    = (state_q == S_IDLE) && start;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign c_valid  = cvalid_q;
    assign C_flat   = c_q;

    for (genvar gi = 0; gi < N; gi++) begin : g_askew
        logic [DW:0] sr_q [gi+1];
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                for (int s = 0; s <= gi; s++) sr_q[s] <= '0;
            end else begin
                sr_q[0] <= {fire, a_col_flat[gi*DW +: DW]};
                for (int s = 1; s <= gi; s++) sr_q[s] <= sr_q[s-1];
            end
        end
        assign a_in[gi][0] = sr_q[gi];
    end

    for (genvar gj = 0; gj < M; gj++) begin : g_bskew
        logic [DW:0] sr_q [gj+1];
        always_ff @(posedge clk) begin
            if (rst || clear) begin
                for (int s = 0; s <= gj; s++) sr_q[s] <= '0;
            end else begin
                sr_q[0] <= {fire, b_row_flat[gj*DW +: DW]};
                for (int s = 1; s <= gj; s++) sr_q[s] <= sr_q[s-1];
            end
        end
        assign b_in[0][gj] = sr_q[gj];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < M; gj++) begin : g_pe
            logic signed [ACCW-1:0] acc_q;
            logic signed [PW-1:0]   prod;
            assign prod = PW'($signed(a_in[gi][gj][DW-1:0])) * PW'($signed(b_in[gi][gj][DW-1:0]));
            always_ff @(posedge clk) begin
                if (rst || clear)
                    acc_q <= '0;
                else if (a_in[gi][gj][DW] && b_in[gi][gj][DW])
                    acc_q <= acc_q + ACCW'(prod);
            end
            assign acc_w[gi][gj] = acc_q;
            if (gj < M - 1) begin : g_a
                logic [DW:0] a_q;
                always_ff @(posedge clk) begin
                    if (rst || clear) a_q <= '0;
                    else              a_q <= a_in[gi][gj];
                end
                assign a_in[gi][gj+1] = a_q;
            end
            if (gi < N - 1) begin : g_b
                logic [DW:0] b_q;
                always_ff @(posedge clk) begin
                    if (rst || clear) b_q <= '0;
                    else              b_q <= b_in[gi][gj];
                end
                assign b_in[gi+1][gj] = b_q;
            end
        end
    end

    function automatic logic [CW-1:0] reduce(input logic signed [ACCW-1:0] v);
`ifdef SYSTOLIC_SAT_EN
        if (v > SAT_MAX)      reduce = CW'(SAT_MAX);
        else if (v < SAT_MIN) reduce = CW'(SAT_MIN);
        else                  reduce = CW'(v);
`else
        reduce = CW'(v);
`endif
    endfunction

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        beat_d   = beat_q;
        drain_d  = drain_q;
        cvalid_d = cvalid_q;
        done_d   = 1'b0;
        c_d      = c_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d      = k_len;
                    beat_d   = '0;
                    drain_d  = '0;
                    cvalid_d = 1'b0;
                    state_d  = (k_len == '0) ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                if (fire) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_d == k_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last PE takes its final product N+M-1 edges after the last beat.
                if (drain_q == DCW'(N + M - 1)) begin
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < M; j++)
                            c_d[(i*M+j)*CW +: CW] = reduce($signed(acc_w[i][j]));
                    cvalid_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            beat_q   <= '0;
            drain_q  <= '0;
            cvalid_q <= 1'b0;
            done_q   <= 1'b0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            beat_q   <= beat_d;
            drain_q  <= drain_d;
            cvalid_q <= cvalid_d;
            done_q   <= done_d;
            c_q      <= c_d;
        end
    end
endmodule
